// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame receiver.
// Optional statistics counters are enabled with the UART_FRAME_STATS_EN macro.
package uart_frame_pkg;

  // Parser states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    HOLD    = 3'd4
  } state_e;

  // Error codes reported alongside the err pulse
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Address width for a buffer of the given depth; never narrower than 1 bit
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_rx_frame_buf.sv
// Payload buffer: simple dual-port RAM, one synchronous write port and one
// registered read port (1-cycle read latency).
module frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk2x,
  input  logic          nrst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  // Synchronous write port
  always_ff @(posedge clk2x) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; output register clears on reset
  always_ff @(posedge clk2x or negedge nrst) begin
    if (!nrst) begin
      rdata_q <= 8'd0;
    end else begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Frame assembler behind the UART byte receiver: parses SOF, LEN,
// payload[LEN], CSUM; holds good frames for the host, reports bad ones.
// Optional statistics counters: define UART_FRAME_STATS_EN.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
  parameter int         TIMEOUT_CYC = 20000,
  localparam int        AW          = addr_width(MAX_LEN)
) (
  input  logic          clk2x,
  input  logic          nrst,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  output logic          frame_valid,
  output logic [7:0]    frame_len,
  input  logic          frame_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [15:0]   good_cnt,
  output logic [15:0]   bad_cnt
);

  localparam int         TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e        state_q, state_d;
  logic          rx_ready_q;
  logic [7:0]    len_q, len_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          valid_q, valid_d;
  logic [7:0]    flen_q, flen_d;
  logic          err_q, err_d;
  err_code_e     code_q, code_d;
  logic          byte_stb;
  logic          buf_we;

  // A held-high level yields exactly one strobe on its rising edge
  assign byte_stb = rx_ready & ~rx_ready_q;
  assign buf_we   = byte_stb && (state_q == PAYLOAD);

  // Next-state logic for the parser, checksum and inter-byte timeout
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    to_cnt_d = to_cnt_q;
    valid_d  = valid_q;
    flen_d   = flen_q;
    err_d    = 1'b0;
    code_d   = code_q;
    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (byte_stb && (rx_data == SOF_BYTE)) begin
          csum_d  = 8'd0;
          state_d = LEN;
        end
      end
      LEN, PAYLOAD, CSUM: begin
        if (byte_stb) begin
          // A strobe always wins over a coincident timeout expiry
          to_cnt_d = '0;
          if (state_q == LEN) begin
            if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
              err_d   = 1'b1;
              code_d  = ERR_LEN;
              state_d = IDLE;
            end else begin
              len_d   = rx_data;
              idx_d   = 8'd0;
              csum_d  = csum_q ^ rx_data;
              state_d = PAYLOAD;
            end
          end else if (state_q == PAYLOAD) begin
            csum_d = csum_q ^ rx_data;
            idx_d  = idx_q + 8'd1;
            if (idx_q == (len_q - 8'd1)) begin
              state_d = CSUM;
            end
          end else begin
            if (rx_data == csum_q) begin
              valid_d = 1'b1;
              flen_d  = len_q;
              state_d = HOLD;
            end else begin
              err_d   = 1'b1;
              code_d  = ERR_CSUM;
              state_d = IDLE;
            end
          end
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d = '0;
          err_d    = 1'b1;
          code_d   = ERR_TIMEOUT;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        to_cnt_d = '0;
        if (frame_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk2x or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      rx_ready_q <= 1'b0;
      len_q      <= 8'd0;
      idx_q      <= 8'd0;
      csum_q     <= 8'd0;
      to_cnt_q   <= '0;
      valid_q    <= 1'b0;
      flen_q     <= 8'd0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready;
      len_q      <= len_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      to_cnt_q   <= to_cnt_d;
      valid_q    <= valid_d;
      flen_q     <= flen_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk2x (clk2x),
    .nrst  (nrst),
    .we    (buf_we),
    .waddr (idx_q[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign frame_valid = valid_q;
  assign frame_len   = flen_q;
  assign err         = err_q;
  assign err_code    = code_q;

`ifdef UART_FRAME_STATS_EN
  logic [15:0] good_cnt_q;
  logic [15:0] bad_cnt_q;
  logic        enter_hold;

  assign enter_hold = (state_q == CSUM) && (state_d == HOLD);

  // Saturating good/bad frame counters
  always_ff @(posedge clk2x or negedge nrst) begin
    if (!nrst) begin
      good_cnt_q <= 16'd0;
      bad_cnt_q  <= 16'd0;
    end else begin
      if (enter_hold && (good_cnt_q != 16'hFFFF)) begin
        good_cnt_q <= good_cnt_q + 16'd1;
      end
      if (err_d && (bad_cnt_q != 16'hFFFF)) begin
        bad_cnt_q <= bad_cnt_q + 16'd1;
      end
    end
  end

  assign good_cnt = good_cnt_q;
  assign bad_cnt  = bad_cnt_q;
`else
  assign good_cnt = 16'd0;
  assign bad_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: table-driven frames with a
// scoreboard of expected events, plus hand-written corner sequences.
module tb_uart_frame_rx;

  localparam int MAX_LEN = 16;
  localparam int TO      = 300;
  localparam int AW      = 4;

  logic          clk2x = 1'b0;
  logic          nrst = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_ready = 1'b0;
  logic          frame_ack = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          frame_valid;
  logic [7:0]    frame_len;
  logic [7:0]    rd_data;
  logic          err;
  logic [1:0]    err_code;
  logic [15:0]   good_cnt;
  logic [15:0]   bad_cnt;

  uart_frame_rx #(
    .MAX_LEN     (MAX_LEN),
    .SOF_BYTE    (8'hA5),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk2x       (clk2x),
    .nrst        (nrst),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .frame_ack   (frame_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .err         (err),
    .err_code    (err_code),
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
  );

  always #5 clk2x = ~clk2x;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_stb = 0;
  int last_obs_cyc = 0;
  int n_good_exp = 0;
  int n_bad_exp  = 0;

  always @(posedge clk2x) cyc <= cyc + 1;

  typedef struct {
    bit         good;
    logic [1:0] code;
    logic [7:0] len;
    int         cyc;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  obs[256];
  int   obs_wr = 0;
  int   obs_rd = 0;
  logic valid_prev = 1'b0;

  // Monitor: records every err pulse and every frame_valid rise
  always @(negedge clk2x) begin
    if (!nrst) begin
      valid_prev = 1'b0;
    end else begin
      if (err && obs_wr < 256) begin
        obs[obs_wr] = '{1'b0, err_code, 8'd0, cyc};
        obs_wr++;
      end
      if (frame_valid && !valid_prev && obs_wr < 256) begin
        obs[obs_wr] = '{1'b1, 2'd0, frame_len, cyc};
        obs_wr++;
      end
      valid_prev = frame_valid;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk2x);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk2x);
    last_stb = cyc;
    rx_ready = 1'b0;
  endtask

  task automatic push_exp(input bit good, input logic [1:0] code, input logic [7:0] len);
    exp_q.push_back('{good, code, len, 0});
    if (good) n_good_exp++;
    else n_bad_exp++;
  endtask

  // Pop each expected event and compare with the next observed one
  task automatic drain(input string tag);
    ev_t e;
    ev_t o;
    int  waited;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      waited = 0;
      while (obs_rd == obs_wr && waited < TO + 50) begin
        @(negedge clk2x);
        waited++;
      end
      if (obs_rd == obs_wr) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s_event: got no event within %0d cycles, expected one", tag, TO + 50);
      end else begin
        o = obs[obs_rd];
        obs_rd++;
        last_obs_cyc = o.cyc;
        check({tag, "_kind"}, 32'(o.good), 32'(e.good));
        if (e.good) check({tag, "_len"}, 32'(o.len), 32'(e.len));
        else        check({tag, "_code"}, 32'(o.code), 32'(e.code));
      end
    end
  endtask

  task automatic read_byte(input int a, output logic [7:0] d);
    @(negedge clk2x);
    rd_addr = a[AW-1:0];
    @(negedge clk2x);
    d = rd_data;
  endtask

  task automatic ack_frame(input string tag);
    @(negedge clk2x);
    frame_ack = 1'b1;
    @(negedge clk2x);
    frame_ack = 1'b0;
    check({tag, "_valid_after_ack"}, 32'(frame_valid), 32'd0);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    repeat (cycles) @(negedge clk2x);
    check({tag, "_no_spurious_event"}, 32'(obs_wr - obs_rd), 32'd0);
  endtask

  task automatic check_stats(input string tag);
`ifdef UART_FRAME_STATS_EN
    check({tag, "_good_cnt"}, 32'(good_cnt), 32'(n_good_exp));
    check({tag, "_bad_cnt"}, 32'(bad_cnt), 32'(n_bad_exp));
`else
    check({tag, "_good_cnt"}, 32'(good_cnt), 32'd0);
    check({tag, "_bad_cnt"}, 32'(bad_cnt), 32'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    check({tag, "_frame_len"}, 32'(frame_len), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_good_cnt"}, 32'(good_cnt), 32'd0);
    check({tag, "_bad_cnt"}, 32'(bad_cnt), 32'd0);
  endtask

  typedef struct {
    int         start;
    int         n;
    int         pl;
    bit         good;
    logic [1:0] code;
    logic [7:0] len;
  } vec_t;

  logic [7:0] stream[$];
  vec_t       vec[7];

  initial begin
    logic [7:0] d;

    // Byte stream for all table frames, concatenated
    stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03,   // good, len 3
               8'hA5, 8'h02, 8'h10, 8'h20, 8'h00,          // bad csum (32)
               8'hA5, 8'h02, 8'h10, 8'h20, 8'h32,          // good, len 2
               8'hA5, 8'h00,                               // bad len 0
               8'hA5, 8'h11,                               // bad len 17
               8'h5A, 8'h77, 8'hA5, 8'h01, 8'hA5, 8'hA4,   // junk, SOF value as payload
               8'hA5, 8'h10};                              // max length frame
    for (int i = 0; i < 16; i++) stream.push_back(8'(i));
    stream.push_back(8'h10);  // xor of 0..15 is 0, so csum = LEN

    vec[0] = '{0,  6, 2, 1'b1, 2'd0, 8'd3};
    vec[1] = '{6,  5, 2, 1'b0, 2'd2, 8'd0};
    vec[2] = '{11, 5, 2, 1'b1, 2'd0, 8'd2};
    vec[3] = '{16, 2, 2, 1'b0, 2'd1, 8'd0};
    vec[4] = '{18, 2, 2, 1'b0, 2'd1, 8'd0};
    vec[5] = '{20, 6, 4, 1'b1, 2'd0, 8'd1};
    vec[6] = '{26, 19, 2, 1'b1, 2'd0, 8'd16};

    // Reset state
    repeat (3) @(negedge clk2x);
    check_reset_outputs("reset");
    nrst = 1'b1;
    repeat (2) @(negedge clk2x);

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      push_exp(vec[v].good, vec[v].code, vec[v].len);
      for (int i = 0; i < vec[v].n; i++) send_byte(stream[vec[v].start + i]);
      drain(tag);
      if (vec[v].good) begin
        check({tag, "_valid"}, 32'(frame_valid), 32'd1);
        check({tag, "_frame_len"}, 32'(frame_len), 32'(vec[v].len));
        for (int i = 0; i < int'(vec[v].len); i++) begin
          read_byte(i, d);
          check($sformatf("%s_rd%0d", tag, i), 32'(d), 32'(stream[vec[v].start + vec[v].pl + i]));
        end
        ack_frame(tag);
      end else begin
        check({tag, "_valid"}, 32'(frame_valid), 32'd0);
      end
      $display("frame %0d: %0d bytes, good=%0b code=%0d len=%0d", v, vec[v].n,
               vec[v].good, vec[v].code, vec[v].len);
    end
    check_quiet("table", 5);

    // Timeout: err exactly TO cycles after the last strobe
    push_exp(1'b0, 2'd3, 8'd0);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h10);
    drain("timeout");
    check("timeout_latency", 32'(last_obs_cyc - last_stb), 32'(TO));
    $display("timeout: err %0d cycles after last strobe", last_obs_cyc - last_stb);
    push_exp(1'b1, 2'd0, 8'd3);
    foreach (stream[i]) if (i < 6) send_byte(stream[i]);
    drain("after_timeout");
    check("err_code_held", 32'(err_code), 32'd3);
    ack_frame("after_timeout");
    $display("after timeout: good frame accepted");

    // HOLD drops a complete second frame; buffer unchanged
    push_exp(1'b1, 2'd0, 8'd1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
    drain("hold");
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h99); send_byte(8'h98);
    check_quiet("hold_drop", 5);
    read_byte(0, d);
    check("hold_buf_unchanged", 32'(d), 32'h42);
    check("hold_still_valid", 32'(frame_valid), 32'd1);
    // Ack coincident with a strobe: the strobe is not taken as SOF
    @(negedge clk2x);
    frame_ack = 1'b1; rx_data = 8'hA5; rx_ready = 1'b1;
    @(negedge clk2x);
    frame_ack = 1'b0; rx_ready = 1'b0;
    check("ack_strobe_valid", 32'(frame_valid), 32'd0);
    send_byte(8'h01); send_byte(8'h66); send_byte(8'h67);
    check_quiet("ack_strobe", 5);
    $display("hold: second frame and ack-cycle strobe ignored");

    // Level held high for 50 cycles consumes one byte only
    push_exp(1'b1, 2'd0, 8'd1);
    @(negedge clk2x);
    rx_data = 8'hA5; rx_ready = 1'b1;
    repeat (50) @(negedge clk2x);
    rx_ready = 1'b0;
    send_byte(8'h01); send_byte(8'h55); send_byte(8'h54);
    drain("level");
    read_byte(0, d);
    check("level_payload", 32'(d), 32'h55);
    ack_frame("level");
    $display("level hold: one byte consumed");

    check_stats("stats");

    // Reset mid-payload: all outputs to reset values, no err
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    @(negedge clk2x);
    nrst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk2x);
    nrst = 1'b1;
    check_quiet("midreset", 10);
    n_good_exp = 0;
    n_bad_exp  = 0;
    push_exp(1'b1, 2'd0, 8'd3);
    foreach (stream[i]) if (i < 6) send_byte(stream[i]);
    drain("midreset_recover");
    ack_frame("midreset_recover");
    check_stats("stats_after_reset");
    $display("mid-frame reset: recovered with good frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
